// File: rtl/lif_neuron_sequencer_if.sv
// Bus between the LIF sequencer and its user: timestep request,
// per-neuron inputs, shared comparator hookup and spike results.
interface lif_neuron_sequencer_if #(
  parameter int W = 4,
  parameter int N = 4
);
  logic           tick;
  logic [N*W-1:0] in_current;
  logic [W-1:0]   leak;
  logic [W-1:0]   minus_teta;
  logic [W-1:0]   cmp_u;
  logic [W-1:0]   cmp_minus_teta;
  logic           cmp_is_spike;
  logic [N-1:0]   spikes;
  logic           spikes_valid;
  logic           busy;
  logic           overrun;
  logic [N*W-1:0] mem_potential;

  modport master (
    output tick, in_current, leak, minus_teta,
    output cmp_is_spike,
    input  cmp_u, cmp_minus_teta, spikes,
    input  spikes_valid, busy, overrun,
    input  mem_potential
  );

  modport slave (
    input  tick, in_current, leak, minus_teta,
    input  cmp_is_spike,
    output cmp_u, cmp_minus_teta, spikes,
    output spikes_valid, busy, overrun,
    output mem_potential
  );
endinterface

// File: rtl/lif_neuron_sequencer.sv
// Leaky integrate-and-fire sweep over N_NEURONS neurons that
// time-share one external spike comparator.
module lif_neuron_sequencer #(
  parameter int n_stage   = 2,
  parameter int N_NEURONS = 4
) (
  input logic clk,
  input logic rst_n,
  lif_neuron_sequencer_if.slave bus
);
  localparam int W  = n_stage + 2;
  localparam int IW =
    (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [IW-1:0] LAST =
    IW'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    COMPARE,
    DONE
  } state_t;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [W-1:0]           u    [N_NEURONS];
  logic [W-1:0]           in_l [N_NEURONS];
  logic [W-1:0]           u_next;
  logic [N_NEURONS-1:0]   spk_acc;
  logic [N_NEURONS-1:0]   spk_new;
  logic [N_NEURONS-1:0]   spikes;
  logic                   spikes_valid;
  logic                   busy;
  logic                   overrun;
  logic [W:0]             sum;
  logic [W-1:0]           sat;
  logic [W-1:0]           integ;

  // Saturate before the leak so a large input cannot wrap to small.
  always_comb begin
    sum   = {1'b0, u[idx]} + {1'b0, in_l[idx]};
    sat   = sum[W] ? '1 : sum[W-1:0];
    integ = (sat > bus.leak) ? sat - bus.leak : '0;
    spk_new      = spk_acc;
    spk_new[idx] = bus.cmp_is_spike;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      idx          <= '0;
      u            <= '{default: '0};
      in_l         <= '{default: '0};
      u_next       <= '0;
      spk_acc      <= '0;
      spikes       <= '0;
      spikes_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      spikes_valid <= 1'b0;
      if (bus.tick && state != IDLE)
        overrun <= 1'b1;
      unique case (state)
        IDLE: begin
          if (bus.tick) begin
            for (int i = 0; i < N_NEURONS; i++)
              in_l[i] <= bus.in_current[i*W +: W];
            idx   <= '0;
            busy  <= 1'b1;
            state <= INTEGRATE;
          end
        end
        INTEGRATE: begin
          u_next <= integ;
          state  <= COMPARE;
        end
        COMPARE: begin
          u[idx]  <= bus.cmp_is_spike ? '0 : u_next;
          spk_acc <= spk_new;
          // cmp_u is u_next, so clearing it zeroes the comparator bus.
          u_next  <= '0;
          if (idx == LAST) begin
            spikes       <= spk_new;
            spikes_valid <= 1'b1;
            state        <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= INTEGRATE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmp_u          = u_next;
  assign bus.cmp_minus_teta = bus.minus_teta;
  assign bus.spikes         = spikes;
  assign bus.spikes_valid   = spikes_valid;
  assign bus.busy           = busy;
  assign bus.overrun        = overrun;

  for (genvar g = 0; g < N_NEURONS; g++) begin : g_mem
    assign bus.mem_potential[g*W +: W] = u[g];
  end
endmodule
